// File: rtl/instr_cache_assoc_pkg.sv
// Shared state encoding and address-field helpers for the set-associative
// instruction cache.
package icache_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FETCH    = 2'd1,
        ST_PREFETCH = 2'd2
    } icache_state_e;

    localparam int INSTR_W = 32;

    function automatic logic [31:0] addr_field(input logic [31:0] addr,
                                               input int lsb,
                                               input int width);
        logic [31:0] mask;
        mask = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
        return (addr >> lsb) & mask;
    endfunction

    // Byte bits [1:0] are never part of any field.
    function automatic logic [31:0] get_offset(input logic [31:0] addr, input int off_w);
        return addr_field(addr, 2, off_w);
    endfunction

    function automatic logic [31:0] get_index(input logic [31:0] addr, input int off_w,
                                              input int idx_w);
        return addr_field(addr, off_w + 2, idx_w);
    endfunction

    function automatic logic [31:0] get_tag(input logic [31:0] addr, input int off_w,
                                            input int idx_w, input int tag_w);
        return addr_field(addr, off_w + 2 + idx_w, tag_w);
    endfunction

endpackage

// File: rtl/instr_cache_assoc_victim_sel.sv
// Victim way for one set: lowest invalid way, otherwise the set's round-robin
// pointer.
module icache_victim_sel #(
    parameter  int WAYS = 2,
    localparam int PW   = (WAYS > 1) ? $clog2(WAYS) : 1
) (
    input  logic [WAYS-1:0] valid_i,
    input  logic [PW-1:0]   ptr_i,
    output logic [PW-1:0]   way_o
);

    always_comb begin
        way_o = ptr_i;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_i[w]) way_o = PW'(w);
        end
    end

endmodule

// File: rtl/instr_cache_assoc.sv
// Set-associative instruction cache with combinational hits, refill bypass and
// round-robin victims. Define ICACHE_PREFETCH_EN to add next-line prefetch.
module instr_cache_assoc
    import icache_pkg::*;
#(
    parameter  int WAYS        = 2,
    parameter  int INDEX_WIDTH = 7,
    parameter  int LINE_INSTRS = 2,
    parameter  int TAG_WIDTH   = 6,
    localparam int OFF_WIDTH   = $clog2(LINE_INSTRS),
    localparam int LINE_WIDTH  = 32 * LINE_INSTRS
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  clear_signal,
    input  logic                  fetch_signal,
    input  logic [31:0]           fetch_addr,
    output logic                  fetch_done,
    output logic [31:0]           fetch_instr,
    output logic                  mem_signal,
    output logic [31:0]           mem_addr,
    input  logic                  mem_done,
    input  logic [LINE_WIDTH-1:0] mem_data
);

    localparam int          SETS      = 1 << INDEX_WIDTH;
    localparam int          PW        = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam logic [31:0] LINE_MASK = ~(32'(4 * LINE_INSTRS) - 32'd1);

    // Arrays: valid and victim pointers are reset, tags and data are not.
    logic [SETS-1:0][WAYS-1:0]  valid_q;
    logic [SETS-1:0][PW-1:0]    ptr_q;
    logic [TAG_WIDTH-1:0]       tag_q  [SETS][WAYS];
    logic [LINE_WIDTH-1:0]      data_q [SETS][WAYS];

    icache_state_e state_q, state_d;
    logic          mem_signal_q, mem_signal_d;
    logic [31:0]   mem_addr_q, mem_addr_d;

    logic [OFF_WIDTH-1:0]   f_off;
    logic [INDEX_WIDTH-1:0] f_idx, l_idx;
    logic [TAG_WIDTH-1:0]   f_tag, l_tag;
    logic                   hit, bypass, fill_en, fill_we;
    logic [PW-1:0]          hit_way, fill_way, ptr_nxt;

    assign f_off = OFF_WIDTH'(get_offset(fetch_addr, OFF_WIDTH));
    assign f_idx = INDEX_WIDTH'(get_index(fetch_addr, OFF_WIDTH, INDEX_WIDTH));
    assign f_tag = TAG_WIDTH'(get_tag(fetch_addr, OFF_WIDTH, INDEX_WIDTH, TAG_WIDTH));
    assign l_idx = INDEX_WIDTH'(get_index(mem_addr_q, OFF_WIDTH, INDEX_WIDTH));
    assign l_tag = TAG_WIDTH'(get_tag(mem_addr_q, OFF_WIDTH, INDEX_WIDTH, TAG_WIDTH));

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_q[f_idx][w] && tag_q[f_idx][w] == f_tag) begin
                hit     = 1'b1;
                hit_way = PW'(w);
            end
        end
    end

    // Refill data is forwarded only to a fetch of the line being refilled.
    assign bypass = (state_q == ST_FETCH) && mem_done && (f_idx == l_idx) && (f_tag == l_tag);

    always_comb begin
        fetch_done  = fetch_signal && (hit || bypass);
        fetch_instr = '0;
        if (hit)
            fetch_instr = data_q[f_idx][hit_way][32 * f_off +: 32];
        else if (bypass)
            fetch_instr = mem_data[32 * f_off +: 32];
    end

`ifdef ICACHE_PREFETCH_EN
    logic [31:0]            next_addr;
    logic [INDEX_WIDTH-1:0] n_idx;
    logic [TAG_WIDTH-1:0]   n_tag;
    logic                   next_hit;

    assign next_addr = mem_addr_q + 32'(4 * LINE_INSTRS);
    assign n_idx     = INDEX_WIDTH'(get_index(next_addr, OFF_WIDTH, INDEX_WIDTH));
    assign n_tag     = TAG_WIDTH'(get_tag(next_addr, OFF_WIDTH, INDEX_WIDTH, TAG_WIDTH));

    always_comb begin
        next_hit = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[n_idx][w] && tag_q[n_idx][w] == n_tag) next_hit = 1'b1;
        end
    end
`endif

    always_comb begin
        state_d      = state_q;
        mem_signal_d = mem_signal_q;
        mem_addr_d   = mem_addr_q;
        fill_en      = 1'b0;
        if (clear_signal) begin
            state_d      = ST_IDLE;
            mem_signal_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (fetch_signal && !fetch_done) begin
                        state_d      = ST_FETCH;
                        mem_signal_d = 1'b1;
                        mem_addr_d   = fetch_addr & LINE_MASK;
                    end
                end
                ST_FETCH: begin
                    if (mem_done) begin
                        fill_en      = 1'b1;
                        state_d      = ST_IDLE;
                        mem_signal_d = 1'b0;
`ifdef ICACHE_PREFETCH_EN
                        if (!next_hit) begin
                            state_d      = ST_PREFETCH;
                            mem_signal_d = 1'b1;
                            mem_addr_d   = next_addr;
                        end
`endif
                    end
                end
`ifdef ICACHE_PREFETCH_EN
                ST_PREFETCH: begin
                    if (mem_done) begin
                        fill_en      = 1'b1;
                        state_d      = ST_IDLE;
                        mem_signal_d = 1'b0;
                    end
                end
`endif
                default: begin
                    state_d      = ST_IDLE;
                    mem_signal_d = 1'b0;
                end
            endcase
        end
    end

    icache_victim_sel #(.WAYS(WAYS)) u_victim (
        .valid_i (valid_q[l_idx]),
        .ptr_i   (ptr_q[l_idx]),
        .way_o   (fill_way)
    );

    assign ptr_nxt = PW'((int'(fill_way) + 1) % WAYS);
    assign fill_we = fill_en && rdy_in && !rst_in;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q      <= ST_IDLE;
            mem_signal_q <= 1'b0;
            mem_addr_q   <= '0;
            valid_q      <= '0;
            ptr_q        <= '0;
        end else if (rdy_in) begin
            state_q      <= state_d;
            mem_signal_q <= mem_signal_d;
            mem_addr_q   <= mem_addr_d;
            if (fill_en) begin
                valid_q[l_idx][fill_way] <= 1'b1;
                ptr_q[l_idx]             <= ptr_nxt;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (fill_we) begin
            data_q[l_idx][fill_way] <= mem_data;
            tag_q[l_idx][fill_way]  <= l_tag;
        end
    end

    assign mem_signal = mem_signal_q;
    assign mem_addr   = mem_addr_q;

endmodule

// File: doc/instr_cache_assoc.md
# instr_cache_assoc

Parametrised set-associative instruction cache sitting between instruction fetch and the memory controller. It generalises the direct-mapped instruction cache in ways, line length and set count, and adds four behaviours:
- victim selection per set;
- same-cycle bypass of refill data to fetch;
- a refill address latched at miss time;
- optional next-line prefetch.

Hits are combinational, so fetch gets its instruction in the request cycle.

## Interface
- WAYS, 2: associativity; power of 2, 1..4
- INDEX_WIDTH, 7: set-index bits; sets = 2**INDEX_WIDTH
- LINE_INSTRS, 2: 32-bit instructions per line; power of 2, 2..8
- TAG_WIDTH, 6: stored tag bits
- OFF_WIDTH (derived): log2(LINE_INSTRS)
- LINE_WIDTH (derived): 32*LINE_INSTRS
- clk_in  input  1  system clock
- rst_in  input  1  synchronous active-high reset
- rdy_in  input  1  when low, all state holds
- clear_signal  input  1  misprediction flush; cancels any outstanding refill
- fetch_signal  input  1  fetch request
- fetch_addr  input  32  instruction byte address
- fetch_done  output  1  combinational hit, or refill bypass
- fetch_instr  output  32  instruction; valid when fetch_done=1
- mem_signal  output  1  line request to memory controller
- mem_addr  output  32  line-aligned request address
- mem_done  input  1  one-cycle pulse: line available
- mem_data  input  LINE_WIDTH  line data; instruction k at bits [32k+31:32k]

## Operation
- Address split:
  - [1:0] ignored;
  - offset = [OFF_WIDTH+1:2];
  - index = next INDEX_WIDTH bits;
  - tag = next TAG_WIDTH bits;
  - bits above are ignored.
- Per way and set: valid bit, tag, line data. Per set: victim pointer of log2(WAYS) bits (absent when WAYS=1).
- Hit: any way in the indexed set with valid=1 and a matching tag. Way priority: lowest index wins (multiple hits are impossible by construction). fetch_instr = that way's line word at the offset.
- Bypass: in FETCH state, when mem_done=1 and fetch_addr's line equals the latched line, fetch_done=1 and fetch_instr comes from mem_data.
- Victim choice: lowest-numbered invalid way; if all are valid, the set's victim pointer. After each fill the pointer becomes filled way + 1, modulo WAYS.
- States are IDLE, FETCH and PREFETCH (PREFETCH only with the macro).
  - IDLE: fetch_signal & ~fetch_done moves to FETCH. At the same edge, mem_signal<=1 and mem_addr<=fetch_addr with bits [OFF_WIDTH+1:0] cleared; the line address is latched.
  - FETCH: on mem_done, write mem_data, the tag and valid=1 into the victim way of the latched set. Then mem_signal<=0 and return to IDLE. The fill always uses the latched address, never fetch_addr.
- clear_signal has priority over everything:
  - state<=IDLE, mem_signal<=0;
  - a coincident mem_done is discarded (no array write);
  - fetch_done may still assert combinationally that cycle.
- Reset: state IDLE, mem_signal=0, mem_addr=0, all valid=0, victim pointers=0. Data arrays are not reset.
- Reset takes effect even when rdy_in=0.

## Timing
- Hit latency: 0 cycles (same-cycle fetch_done).
- Miss: fetch seen at edge N, so mem_signal=1 from cycle N+1. mem_signal holds high until the edge after mem_done.
- mem_done in cycle M gives a bypass hit in M and the line readable as a normal hit from M+1.
- A new miss cannot be issued earlier than M+1.
- mem_addr is stable while mem_signal=1.
- rdy_in=0 freezes state; combinational outputs still follow current state and arrays.

## Configuration
- ICACHE_PREFETCH_EN defined:
  - after a FETCH fill completes without clear, check whether line+1 (mem_addr + 4*LINE_INSTRS, same wrap rules) hits;
  - if it misses, go to PREFETCH and keep mem_signal=1 with mem_addr=next line;
  - the fill rule is the same as FETCH, but no bypass;
  - demand misses in PREFETCH wait until it completes;
  - clear_signal aborts PREFETCH.
- ICACHE_PREFETCH_EN undefined: PREFETCH state and the next-line logic are absent; FETCH always returns to IDLE.

## Structure
- Package icache_pkg: state encoding (IDLE/FETCH/PREFETCH), plus address-field helper functions for offset, index and tag extraction from the parameters.
- Sub-module icache_victim_sel: combinational victim way from the set's valid vector and victim pointer.

## Test plan
- After reset, fetch 0x0000_0000 → fetch_done=0, mem_signal=1 and mem_addr=0x0 next cycle. Return mem_done with data {0x0000_0013, 0x0010_0093} → bypass fetch_done=1, instr 0x0010_0093. Then fetch 0x4 → hit, instr 0x0000_0013.
- With WAYS=2, fill 0x000, 0x400, 0x800 (same set 0).
  - 0x800 evicts way 0 (0x000).
  - 0x400 still hits; 0x000 misses.
- clear_signal asserted in the same cycle as mem_done → no fill, mem_signal=0 next cycle, refetch of the same address misses again.
- Miss latched at 0x0000_0108, fetch_addr changes to 0x0000_0300 during the wait → fill lands at 0x108's set and tag; 0x300 still misses.
- rdy_in low for 3 cycles across mem_done being held → state frozen; fill completes on the first rdy_in-high edge with mem_done=1.
- With ICACHE_PREFETCH_EN, miss at 0x000 → after fill, mem_addr=0x008 and mem_signal stays 1. After that fill, fetch 0x008 hits with 0 latency.
